rr_arbiter32: RTL and testbench
===============================

RR_ARBITER32 -- requirements
Module: rr_arbiter32

Interface
REQ-001 SHALL have parameter N, default 32: number of requesters, also the width of req.
REQ-002 SHALL have parameter W, default 5: width of gnt_idx, equal to log2(N), and sized to drive the 5-to-32 one-hot decoder downstream.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum number of cycles a grant waits for ack.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port req, input, N: per-requester request level; bit i belongs to requester i.
REQ-007 Port ack, input, 1: the consumer accepts the current grant; sampled only while gnt_valid=1.
REQ-008 Port gnt_valid, output, 1: gnt_idx holds a live grant.
REQ-009 Port gnt_idx, output, W: binary index of the granted requester.
REQ-010 Port timeout_err, output, 1: one-cycle pulse when a grant is dropped because it was never acked.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-012 SHALL hold an internal W-bit priority pointer ptr.
- ptr names the highest-priority index.
- The search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-013 IDLE with req!=0 at edge n: SHALL load gnt_idx with the first set bit in search order and enter GRANT, so gnt_valid=1 in cycle n+1.
- Latency from request to grant is 1 cycle.
REQ-014 IDLE with req==0: SHALL stay in IDLE; gnt_idx holds its last value.
REQ-015 In GRANT, gnt_idx SHALL stay stable until ack or timeout, even if req[gnt_idx] drops (the grant is locked).
REQ-016 ack=1 in GRANT at edge n: SHALL set ptr to gnt_idx+1 mod N (31 wraps to 0).
- If another request is pending, it SHALL re-arbitrate in the same edge from the updated ptr, giving back-to-back grants with no bubble.
- If no request is pending, it SHALL return to IDLE.
REQ-017 The re-arbitration in REQ-016 SHALL use the current req, including the just-acked bit; that bit has lowest priority at that point.
REQ-018 SHALL count GRANT cycles without ack in a wait counter.
- The counter clears on every new grant.
REQ-019 If the counter reaches TIMEOUT-1 and ack=0 at that edge: SHALL go to IDLE, set gnt_valid=0, pulse timeout_err=1 for exactly one cycle, and set ptr to gnt_idx+1 mod N.
REQ-020 ack=1 on the final timeout cycle SHALL take precedence: a normal ack, with no timeout_err.
REQ-021 gnt_valid SHALL be high for at most TIMEOUT consecutive cycles per grant.
REQ-022 ack while gnt_valid=0 SHALL be ignored.
REQ-023 All outputs SHALL be registered; there is no combinational path from req or ack to any output.

Reset
REQ-024 rst=1 at an edge SHALL force the following, regardless of state or inputs, and in the same cycle shall override ack and timeout:
- state=IDLE, ptr=0, wait counter=0;
- gnt_valid=0, gnt_idx=0, timeout_err=0.
REQ-025 Reset in the middle of a grant SHALL abandon that grant without a timeout_err pulse.
- Arbitration SHALL resume on the first edge after rst deasserts, from ptr=0.

Structure
REQ-026 Shared package arb_pkg SHALL hold:
- the state encoding (IDLE, GRANT);
- the defaults N=32, W=5, TIMEOUT=16.
REQ-027 SHALL instantiate one combinational sub-module, rr_pick.
- Inputs: req and ptr.
- Outputs: any (1 bit) and idx (W bits, first set bit in search order).
- rr_arbiter32 holds all state.

Verification
REQ-028 Release rst, then drive req=32'h0000_0001 -> gnt_valid=1 and gnt_idx=0 one cycle later; ack=1 for one cycle -> IDLE, ptr=1.
REQ-029 Hold req=32'hFFFF_FFFF and ack=1 continuously -> gnt_idx runs 0,1,...,31,0 on consecutive cycles with gnt_valid never dropping.
REQ-030 Wrap-around: grant index 30 and ack it, then drive req=32'h8000_0001 -> grant 31; ack -> grant 0 on the next cycle.
REQ-031 Timeout: req=32'h0000_0020 with ack=0 -> gnt_valid=1 with gnt_idx=5 for exactly 16 cycles, then timeout_err=1 for one cycle and gnt_valid=0; next grant search starts at 6.
REQ-032 Lock and precedence:
- Drop req[5] during the grant to 5 -> gnt_idx stays 5 until ack.
- ack on cycle 16 -> no timeout_err.
REQ-033 Assert rst for one cycle during a grant to index 9 -> all outputs 0 the next cycle, no timeout_err; with req=32'h0000_0202 after release, the grant is 1.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared state encoding and default sizing for the 32-way
//                round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int c_default_n       = 32;
    localparam int c_default_w       = 5;
    localparam int c_default_timeout = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker: first set request bit at
//                or above ptr, else the first set bit from index 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = c_default_n,
    parameter int W = c_default_w
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [W-1:0] w_idx_hi;
    logic [W-1:0] w_idx_lo;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (W'(i) >= ptr);
        end
    end

    assign w_hi = req & w_mask;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        w_idx_hi = '0;
        w_idx_lo = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_hi[i]) begin
                w_idx_hi = W'(i);
            end
            if (req[i]) begin
                w_idx_lo = W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = (|w_hi) ? w_idx_hi : w_idx_lo;

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_arbiter32.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter32
//  Description : Round-robin arbiter with locked grants, ack handshake,
//                back-to-back re-arbitration and grant timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter32
    import arb_pkg::*;
#(
    parameter int N       = c_default_n,
    parameter int W       = c_default_w,
    parameter int TIMEOUT = c_default_timeout
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic         timeout_err
);

    localparam int            c_cw       = $clog2(TIMEOUT + 1);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(TIMEOUT - 1);
    localparam logic [W-1:0]  c_last_idx = W'(N - 1);

    arb_state_t      r_state;
    arb_state_t      w_state_n;
    logic [W-1:0]    r_ptr;
    logic [W-1:0]    w_ptr_n;
    logic [W-1:0]    r_gnt_idx;
    logic [W-1:0]    w_gnt_idx_n;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_n;
    logic            r_timeout_err;
    logic            w_timeout_err_n;

    logic [W-1:0]    w_idx_inc;
    logic [W-1:0]    w_pick_ptr;
    logic            w_pick_any;
    logic [W-1:0]    w_pick_idx;

    assign w_idx_inc  = (r_gnt_idx == c_last_idx) ? '0 : r_gnt_idx + W'(1);
    // While granting, the picker is only consulted on ack, where priority
    // starts just past the retiring grant.
    assign w_pick_ptr = (r_state == GRANT) ? w_idx_inc : r_ptr;

    rr_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req (req),
        .ptr (w_pick_ptr),
        .any (w_pick_any),
        .idx (w_pick_idx)
    );

    always_comb begin
        w_state_n       = r_state;
        w_ptr_n         = r_ptr;
        w_gnt_idx_n     = r_gnt_idx;
        w_cnt_n         = r_cnt;
        w_timeout_err_n = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_n   = GRANT;
                    w_gnt_idx_n = w_pick_idx;
                    w_cnt_n     = '0;
                end
            end
            GRANT: begin
                if (ack) begin
                    w_ptr_n = w_idx_inc;
                    if (w_pick_any) begin
                        w_gnt_idx_n = w_pick_idx;
                        w_cnt_n     = '0;
                    end else begin
                        w_state_n = IDLE;
                    end
                end else if (r_cnt == c_cnt_last) begin
                    w_state_n       = IDLE;
                    w_timeout_err_n = 1'b1;
                    w_ptr_n         = w_idx_inc;
                end else begin
                    w_cnt_n = r_cnt + c_cw'(1);
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_gnt_idx     <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_ptr         <= w_ptr_n;
            r_gnt_idx     <= w_gnt_idx_n;
            r_cnt         <= w_cnt_n;
            r_timeout_err <= w_timeout_err_n;
        end
    end

    assign gnt_valid   = (r_state == GRANT);
    assign gnt_idx     = r_gnt_idx;
    assign timeout_err = r_timeout_err;

endmodule : rr_arbiter32
`default_nettype wire

// File: tb/tb_rr_arbiter32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter32
//  Description : Self-checking bench for rr_arbiter32 (vector table, directed
//                corner sequences, randomized traffic against a model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter32;

    localparam int c_n  = 32;
    localparam int c_to = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req = '0;
    logic        ack = 1'b0;
    logic        gnt_valid;
    logic [4:0]  gnt_idx;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    // Reference model: "who holds the grant and for how long", plus the
    // index that currently has top priority.
    int m_valid = 0;
    int m_idx   = 0;
    int m_top   = 0;
    int m_age   = 0;
    int m_terr  = 0;

    typedef struct {
        logic        r;
        logic [31:0] q;
        logic        a;
        logic        ev;
        logic [4:0]  ei;
        logic        et;
    } vec_t;

    vec_t tbl[14];

    rr_arbiter32 #(
        .N       (32),
        .W       (5),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .gnt_valid   (gnt_valid),
        .gnt_idx     (gnt_idx),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int first_from(input logic [31:0] q, input int top);
        for (int k = 0; k < c_n; k++) begin
            if (q[(top + k) % c_n]) return (top + k) % c_n;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [31:0] q, input logic a);
        m_terr = 0;
        if (r) begin
            m_valid = 0; m_idx = 0; m_top = 0; m_age = 0;
        end else if (m_valid == 0) begin
            if (q != 0) begin
                m_valid = 1; m_idx = first_from(q, m_top); m_age = 1;
            end
        end else if (a) begin
            m_top = (m_idx + 1) % c_n;
            if (q != 0) begin
                m_idx = first_from(q, m_top); m_age = 1;
            end else begin
                m_valid = 0;
            end
        end else if (m_age == c_to) begin
            m_valid = 0; m_terr = 1; m_top = (m_idx + 1) % c_n;
        end else begin
            m_age = m_age + 1;
        end
    endtask

    task automatic tick(input logic r, input logic [31:0] q, input logic a);
        rst = r; req = q; ack = a;
        model_step(r, q, a);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic ev, input logic [4:0] ei, input logic et);
        total++;
        if (gnt_valid !== ev || gnt_idx !== ei || timeout_err !== et) begin
            bad++;
            $display("FAIL %s: got valid=%0b idx=%0d terr=%0b, want valid=%0b idx=%0d terr=%0b",
                     nm, gnt_valid, gnt_idx, timeout_err, ev, ei, et);
        end
    endtask

    initial begin
        // rst, req, ack -> valid, idx, timeout_err after the edge
        tbl[0]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0001, 1'b0, 1'b1, 5'd0,  1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0};
        tbl[3]  = '{1'b0, 32'h0000_0003, 1'b0, 1'b1, 5'd1,  1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd1,  1'b0};
        tbl[5]  = '{1'b0, 32'h4000_0000, 1'b0, 1'b1, 5'd30, 1'b0};
        tbl[6]  = '{1'b0, 32'h8000_0001, 1'b1, 1'b1, 5'd31, 1'b0};
        tbl[7]  = '{1'b0, 32'h8000_0001, 1'b1, 1'b1, 5'd0,  1'b0};
        tbl[8]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0};
        tbl[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0};
        tbl[10] = '{1'b0, 32'h8000_0000, 1'b1, 1'b1, 5'd31, 1'b0};
        tbl[11] = '{1'b0, 32'h8000_0001, 1'b1, 1'b1, 5'd0,  1'b0};
        tbl[12] = '{1'b0, 32'h0000_0001, 1'b1, 1'b1, 5'd0,  1'b0};
        tbl[13] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0};

        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].r, tbl[i].q, tbl[i].a);
            chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].et);
        end

        // Full rotation with every requester active and ack held high.
        tick(1'b1, 32'h0, 1'b0);
        chk("rr_reset", 1'b0, 5'd0, 1'b0);
        tick(1'b0, 32'hFFFF_FFFF, 1'b0);
        chk("rr_first", 1'b1, 5'd0, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            tick(1'b0, 32'hFFFF_FFFF, 1'b1);
            chk($sformatf("rr_step%0d", k), 1'b1, 5'(k % 32), 1'b0);
        end
        tick(1'b0, 32'h0, 1'b1);
        chk("rr_drain", 1'b0, 5'd0, 1'b0);

        // Timeout: 16 grant cycles, one-cycle error pulse, search resumes at 6.
        tick(1'b0, 32'h0000_0020, 1'b0);
        chk("to_c1", 1'b1, 5'd5, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            tick(1'b0, 32'h0000_0020, 1'b0);
            chk($sformatf("to_c%0d", c), 1'b1, 5'd5, 1'b0);
        end
        tick(1'b0, 32'h0000_0021, 1'b0);
        chk("to_pulse", 1'b0, 5'd5, 1'b1);
        tick(1'b0, 32'h0000_0021, 1'b0);
        chk("to_next", 1'b1, 5'd0, 1'b0);
        tick(1'b0, 32'h0, 1'b1);
        chk("to_drain", 1'b0, 5'd0, 1'b0);

        // Locked grant with its request dropped, acked on the final cycle.
        tick(1'b0, 32'h0000_0020, 1'b0);
        chk("lk_c1", 1'b1, 5'd5, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            tick(1'b0, 32'h0, 1'b0);
            chk($sformatf("lk_c%0d", c), 1'b1, 5'd5, 1'b0);
        end
        tick(1'b0, 32'h0, 1'b1);
        chk("lk_ack16", 1'b0, 5'd5, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        chk("lk_quiet", 1'b0, 5'd5, 1'b0);

        // Reset in the middle of a grant to 9.
        tick(1'b0, 32'h0000_0200, 1'b0);
        chk("rs_grant9", 1'b1, 5'd9, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        chk("rs_hold9", 1'b1, 5'd9, 1'b0);
        tick(1'b1, 32'h0000_0200, 1'b1);
        chk("rs_clear", 1'b0, 5'd0, 1'b0);
        tick(1'b0, 32'h0000_0202, 1'b0);
        chk("rs_resume", 1'b1, 5'd1, 1'b0);
        tick(1'b0, 32'h0, 1'b1);
        chk("rs_drain", 1'b0, 5'd1, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] q;
            logic        a;
            logic        r;
            case ($urandom_range(0, 3))
                0:       q = 32'h0;
                1:       q = $urandom;
                2:       q = $urandom & $urandom & $urandom;
                default: q = 32'h1 << $urandom_range(0, 31);
            endcase
            a = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 299) == 0);
            tick(r, q, a);
            chk("rand", m_valid[0], 5'(m_idx), m_terr[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arbiter32
`default_nettype wire
